bamse_uart_tx: RTL and testbench



---
 rtl/bamse_uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_bamse_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bamse_uart_tx.sv
// Buffered 8N1 UART transmitter on the bamse PicoBlaze port bus: FIFO, programmable divisor, drain IRQ.
// Define BAMSE_UART_TX_IRQ_EN to build the ie control bit and the interrupt output.
module bamse_uart_tx #(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter int          FIFO_AW   = 2,
    parameter logic [15:0] RESET_DIV = 16'd433
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] port_in,
    input  logic       wen,
    input  logic       ren,
    output logic [7:0] port_out,
    output logic       interrupt,
    output logic       tx
);

    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nxt;
    logic [15:0]        div;
    logic [15:0]        cnt, cnt_nxt;
    logic [2:0]         bitcnt, bitcnt_nxt;
    logic [7:0]         shreg, shreg_nxt;
    logic               tx_nxt;
    logic               bnd;
    logic               pop, shift;
    logic               ovf;

    logic [7:0]         mem [FULL_CNT];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full, busy;
    logic               push, ovf_set;

    logic [7:0]         off;
    logic               hit;
    logic               wr_fifo, wr_divl, wr_divh, rd_stat;
    logic [7:0]         rd_data;

    // Offset arithmetic lets BASE_ADDR sit on any boundary, not just multiples of 4.
    assign off     = port_id - BASE_ADDR;
    assign hit     = (off[7:2] == 6'd0);
    assign wr_fifo = wen & hit & (off[1:0] == 2'd0);
    assign wr_divl = wen & hit & (off[1:0] == 2'd1);
    assign wr_divh = wen & hit & (off[1:0] == 2'd2);
    assign rd_stat = ren & hit & (off[1:0] == 2'd0);

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign busy    = (state != IDLE) | ~empty;
    assign bnd     = (cnt == 16'd0);

    // Pop is decided before push so a full FIFO draining this cycle still accepts the byte.
    assign push    = wr_fifo & (~full | pop);
    assign ovf_set = wr_fifo & full & ~pop;

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        shift      = 1'b0;
        bitcnt_nxt = bitcnt;
        cnt_nxt    = bnd ? cnt : cnt - 16'd1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                    cnt_nxt   = div;
                end
            end
            START: begin
                if (bnd) begin
                    state_nxt  = DATA;
                    cnt_nxt    = div;
                    bitcnt_nxt = 3'd0;
                end
            end
            DATA: begin
                if (bnd) begin
                    cnt_nxt = div;
                    shift   = 1'b1;
                    if (bitcnt == 3'd7) state_nxt = STOP;
                    else                bitcnt_nxt = bitcnt + 3'd1;
                end
            end
            STOP: begin
                if (bnd) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                        cnt_nxt   = div;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        shreg_nxt = shreg;
        if (pop)        shreg_nxt = mem[rptr];
        else if (shift) shreg_nxt = {1'b1, shreg[7:1]};

        // tx is a flop fed from next-state values so the line never glitches on state decode.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
        end else begin
            state <= state_nxt;
            tx    <= tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        cnt    <= cnt_nxt;
        bitcnt <= bitcnt_nxt;
        shreg  <= shreg_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= port_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a set in the same cycle as a status read wins.
    always_ff @(posedge clk) begin
        if (rst)          ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (rd_stat) ovf <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= RESET_DIV;
        end else begin
            if (wr_divl) div[7:0]  <= port_in;
            if (wr_divh) div[15:8] <= port_in;
        end
    end

`ifdef BAMSE_UART_TX_IRQ_EN
    logic ie;
    logic wr_ctrl;

    assign wr_ctrl = wen & hit & (off[1:0] == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            ie        <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (wr_ctrl) ie <= port_in[0];
            interrupt <= ie & empty & (state == IDLE);
        end
    end
`else
    assign interrupt = 1'b0;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (hit) begin
            case (off[1:0])
                2'd0:    rd_data = {5'b0, ovf, full, busy};
                2'd1:    rd_data = div[7:0];
                2'd2:    rd_data = div[15:8];
`ifdef BAMSE_UART_TX_IRQ_EN
                2'd3:    rd_data = {7'b0, ie};
`endif
                default: rd_data = 8'h00;
            endcase
        end
    end

    // Read data is registered every cycle; port_id is held two cycles by the CPU on INPUT.
    always_ff @(posedge clk) begin
        if (rst) port_out <= 8'h00;
        else     port_out <= rd_data;
    end

endmodule

// File: tb/tb_bamse_uart_tx.sv
// Directed testbench for bamse_uart_tx: register access, framing, FIFO overflow, divisor change, IRQ.
module tb_bamse_uart_tx;

    localparam logic [7:0] A = 8'h10;
`ifdef BAMSE_UART_TX_IRQ_EN
    localparam logic IE = 1'b1;
`else
    localparam logic IE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] port_id, port_in, port_out;
    logic       wen, ren, interrupt, tx;

    int n_chk  = 0;
    int n_fail = 0;

    logic tx_log [0:1023];
    int   log_n = 0;
    bit   rec   = 1'b0;

    bamse_uart_tx dut (
        .clk       (clk),
        .rst       (rst),
        .port_id   (port_id),
        .port_in   (port_in),
        .wen       (wen),
        .ren       (ren),
        .port_out  (port_out),
        .interrupt (interrupt),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    // Index n of the log holds tx as it stands after the n-th rising edge following log_start.
    always @(negedge clk) begin
        if (rec && log_n < 1024) begin
            tx_log[log_n] = tx;
            log_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a;
        port_in = d;
        wen     = 1'b1;
        tick();
        wen     = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        port_id = a;
        ren     = 1'b1;
        tick();
        ren     = 1'b0;
        check(tag, port_out, exp);
    endtask

    task automatic log_start();
        log_n = 0;
        rec   = 1'b1;
    endtask

    task automatic chk_bits(input string tag, input int start, input int len, input logic v);
        logic [31:0] got, exp;
        got = '0;
        exp = '0;
        for (int i = 0; i < len; i++) begin
            got = {got[30:0], (start + i < log_n) ? tx_log[start + i] : 1'bx};
            exp = {exp[30:0], v};
        end
        check(tag, got, exp);
    endtask

    task automatic chk_frame(input string tag, input int start, input logic [7:0] b, input int d);
        int p;
        p = d + 1;
        chk_bits($sformatf("%s start", tag), start, p, 1'b0);
        for (int i = 0; i < 8; i++)
            chk_bits($sformatf("%s b%0d", tag, i), start + p * (i + 1), p, b[i]);
        chk_bits($sformatf("%s stop", tag), start + 9 * p, p, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; port_id = 8'h00; port_in = 8'h00; wen = 1'b0; ren = 1'b0;
        repeat (3) tick();
        check("reset tx", tx, 1);
        check("reset port_out", port_out, 0);
        check("reset interrupt", interrupt, 0);
        rst = 1'b0;

        rdchk("reset divl", A + 8'd1, 8'hB1);
        rdchk("reset divh", A + 8'd2, 8'h01);
        rdchk("reset ctrl", A + 8'd3, 8'h00);
        rdchk("reset status", A, 8'h00);
        rdchk("miss above", A + 8'd5, 8'h00);
        rdchk("miss below", A - 8'd1, 8'h00);
        check("idle interrupt", interrupt, 0);

        // Reset in the middle of a frame with a second byte still queued.
        wr(A + 8'd1, 8'd3);
        wr(A + 8'd2, 8'd0);
        wr(A, 8'hAA);
        wr(A, 8'h11);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("midframe rst tx", tx, 1);
        tick();
        rst = 1'b0;
        rdchk("post rst status", A, 8'h00);
        rdchk("post rst divl", A + 8'd1, 8'hB1);
        rdchk("post rst divh", A + 8'd2, 8'h01);
        repeat (5) tick();
        check("post rst idle tx", tx, 1);

        // Single byte, DIV=3: 40-clock frame starting the cycle after the push edge.
        wr(A + 8'd1, 8'd3);
        wr(A + 8'd2, 8'd0);
        log_start();
        wr(A, 8'h55);
        repeat (44) tick();
        chk_bits("sb pre", 0, 2, 1'b1);
        chk_frame("sb", 2, 8'h55, 3);
        chk_bits("sb post", 42, 3, 1'b1);
        rdchk("sb status", A, 8'h00);

        // Back-to-back, DIV=1: second start bit directly follows the first stop bit.
        wr(A + 8'd1, 8'd1);
        log_start();
        wr(A, 8'hA0);
        wr(A, 8'h0F);
        repeat (45) tick();
        chk_frame("b2b0", 2, 8'hA0, 1);
        chk_frame("b2b1", 22, 8'h0F, 1);
        chk_bits("b2b post", 42, 3, 1'b1);

        // Overflow, DIV=9: 01 pops at the second write edge, so 02..05 fill the FIFO and 06 drops.
        wr(A + 8'd1, 8'd9);
        log_start();
        for (int i = 1; i <= 5; i++) wr(A, 8'(i));
        wr(A, 8'h06);
        rdchk("ovf status set", A, 8'h07);
        rdchk("ovf status clr", A, 8'h03);
        repeat (520) tick();
        for (int k = 0; k < 5; k++)
            chk_frame($sformatf("ovf%0d", k), 2 + 100 * k, 8'(k + 1), 9);
        chk_bits("ovf post", 502, 10, 1'b1);
        rdchk("ovf drained", A, 8'h00);

        // DIV 7 -> 1 written during bit 3: bit 3 keeps 8 clocks, later bits take 2.
        wr(A + 8'd1, 8'd7);
        log_start();
        wr(A, 8'h96);
        repeat (35) tick();
        wr(A + 8'd1, 8'd1);
        repeat (25) tick();
        chk_bits("dc start", 2, 8, 1'b0);
        chk_bits("dc b0", 10, 8, 1'b0);
        chk_bits("dc b1", 18, 8, 1'b1);
        chk_bits("dc b2", 26, 8, 1'b1);
        chk_bits("dc b3", 34, 8, 1'b0);
        chk_bits("dc b4", 42, 2, 1'b1);
        chk_bits("dc b5", 44, 2, 1'b0);
        chk_bits("dc b6", 46, 2, 1'b0);
        chk_bits("dc b7", 48, 2, 1'b1);
        chk_bits("dc stop", 50, 2, 1'b1);
        chk_bits("dc post", 52, 4, 1'b1);
        rec = 1'b0;

        // Drain interrupt at DIV=0.
        wr(A + 8'd1, 8'd0);
        wr(A + 8'd3, 8'd1);
        tick();
        check("irq ie idle", interrupt, IE);
        rdchk("ctrl readback", A + 8'd3, {7'b0, IE});
        wr(A, 8'hC3);
        check("irq push edge", interrupt, IE);
        tick();
        check("irq fall", interrupt, 0);
        check("irq start tx", tx, 0);
        repeat (9) tick();
        check("irq stop tx", tx, 1);
        check("irq in stop", interrupt, 0);
        tick();
        check("irq at idle", interrupt, 0);
        tick();
        check("irq rise", interrupt, IE);
        wr(A, 8'h00);
        check("irq 2nd push edge", interrupt, IE);
        tick();
        check("irq 2nd fall", interrupt, 0);
        repeat (15) tick();
        check("irq redrained", interrupt, IE);
        check("final tx", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
